// File: rtl/axis_output_stream_merger_pkg.sv
// Shared definitions for the transpose-conv output stream merger:
// arbitration states, source ids and the default packet-length limit.
package axis_output_stream_merger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } merge_state_e;

  localparam logic SRC_WEIGHT = 1'b0;
  localparam logic SRC_IFMAP  = 1'b1;

  localparam int DEFAULT_MAX_PKT_LEN = 4096;

endpackage

// File: rtl/axis_merge_fifo.sv
// Synchronous first-word-fall-through FIFO: dout shows the head entry whenever
// the FIFO is non-empty. Push while full and pop while empty are ignored.
module axis_merge_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == FULL_LEVEL);
  assign empty     = (level_r == {(AW+1){1'b0}});
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and exact occupancy; reset also clears the array so dout reads zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/axis_output_stream_merger.sv
// Packet-level round-robin merge of the weight-side and ifmap-side result
// streams into one source-tagged AXI-Stream, buffered by a FWFT FIFO.
module axis_output_stream_merger
  import axis_output_stream_merger_pkg::*;
#(
  parameter int DW          = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_AW     = 4,
  parameter int MAX_PKT_LEN = DEFAULT_MAX_PKT_LEN,
  parameter int LEN_W       = 13
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [DW-1:0]      s0_axis_tdata,
  input  logic               s0_axis_tvalid,
  output logic               s0_axis_tready,
  input  logic               s0_axis_tlast,
  input  logic [DW-1:0]      s1_axis_tdata,
  input  logic               s1_axis_tvalid,
  output logic               s1_axis_tready,
  input  logic               s1_axis_tlast,
  output logic [DW-1:0]      m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [15:0]        pkt_count_0,
  output logic [15:0]        pkt_count_1,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               len_error
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

  merge_state_e     state_r;
  logic             last_grant_r;
  logic [LEN_W-1:0] word_cnt_r;
  logic [15:0]      pkt_count_0_r;
  logic [15:0]      pkt_count_1_r;
  logic             len_error_r;

  logic             sel_valid_s;
  logic             sel_last_s;
  logic             sel_src_s;
  logic [DW-1:0]    sel_data_s;
  logic             s0_ready_s;
  logic             s1_ready_s;
  logic             accept_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [DW+1:0]    fifo_din_s;
  logic [DW+1:0]    fifo_dout_s;

  // Route the granted source toward the FIFO; nothing is accepted while idle or full.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_src_s   = SRC_WEIGHT;
    sel_data_s  = '0;
    s0_ready_s  = 1'b0;
    s1_ready_s  = 1'b0;
    case (state_r)
      ST_GRANT0: begin
        sel_valid_s = s0_axis_tvalid;
        sel_last_s  = s0_axis_tlast;
        sel_src_s   = SRC_WEIGHT;
        sel_data_s  = s0_axis_tdata;
        s0_ready_s  = ~fifo_full_s;
      end
      ST_GRANT1: begin
        sel_valid_s = s1_axis_tvalid;
        sel_last_s  = s1_axis_tlast;
        sel_src_s   = SRC_IFMAP;
        sel_data_s  = s1_axis_tdata;
        s1_ready_s  = ~fifo_full_s;
      end
      default: begin
        sel_valid_s = 1'b0;
      end
    endcase
  end

  assign accept_s   = sel_valid_s & (s0_ready_s | s1_ready_s);
  assign fifo_din_s = {sel_src_s, sel_last_s, sel_data_s};

  // Arbitration FSM with per-source packet counters and the over-length monitor.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= SRC_IFMAP;
      word_cnt_r    <= '0;
      pkt_count_0_r <= 16'h0000;
      pkt_count_1_r <= 16'h0000;
      len_error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (s0_axis_tvalid && s1_axis_tvalid) begin
            state_r <= (last_grant_r == SRC_WEIGHT) ? ST_GRANT1 : ST_GRANT0;
          end else if (s0_axis_tvalid) begin
            state_r <= ST_GRANT0;
          end else if (s1_axis_tvalid) begin
            state_r <= ST_GRANT1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (accept_s) begin
            if (sel_last_s) begin
              state_r      <= ST_IDLE;
              last_grant_r <= sel_src_s;
              word_cnt_r   <= '0;
              if (sel_src_s == SRC_WEIGHT) begin
                pkt_count_0_r <= pkt_count_0_r + 16'd1;
              end else begin
                pkt_count_1_r <= pkt_count_1_r + 16'd1;
              end
            end else if (word_cnt_r == MAX_LEN) begin
              // Counter saturates; the word itself still goes through untouched.
              len_error_r <= 1'b1;
            end else begin
              word_cnt_r <= word_cnt_r + 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  axis_merge_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (accept_s),
    .pop     (m_axis_tvalid & m_axis_tready),
    .din     (fifo_din_s),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  assign s0_axis_tready = s0_ready_s;
  assign s1_axis_tready = s1_ready_s;
  assign m_axis_tvalid  = ~fifo_empty_s;
  assign m_axis_tdata   = fifo_dout_s[DW-1:0];
  assign m_axis_tlast   = fifo_dout_s[DW];
  assign m_axis_tuser   = fifo_dout_s[DW+1];
  assign pkt_count_0    = pkt_count_0_r;
  assign pkt_count_1    = pkt_count_1_r;
  assign busy           = (state_r != ST_IDLE) | ~fifo_empty_s;
  assign len_error      = len_error_r;

endmodule
